// File: rtl/tone_gen.sv
// Square-wave tone generator driven by a divided-clock tick stream.
// Note changes and silencing take effect only at half-period boundaries.
module tone_gen #(
  parameter int unsigned CNT_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] note,
  input  logic [1:0] octave,
  output logic       audio,
  output logic       note_active
);

  typedef enum logic [0:0] {IDLE, PLAY} state_e;

  state_e             state_q, state_d;
  logic               tick_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic               audio_q, audio_d;
  logic               active_q;
  logic [3:0]         pend_note_q, pend_note_d;
  logic [1:0]         pend_oct_q, pend_oct_d;
  logic               pend_flag_q, pend_flag_d;

  logic               tick_rise_c;
  logic               boundary_c;
  logic               eff_flag_c;
  logic [3:0]         eff_note_c;
  logic [1:0]         eff_oct_c;

  function automatic logic playable(input logic [3:0] n);
    return (n >= 4'd1) && (n <= 4'd12);
  endfunction

  // Base half-period in ticks for C..B, shifted down by the octave.
  function automatic logic [CNT_W-1:0] half_of(input logic [3:0] n, input logic [1:0] oct);
    logic [CNT_W-1:0] base;
    case (n)
      4'd1:    base = CNT_W'(1911);
      4'd2:    base = CNT_W'(1804);
      4'd3:    base = CNT_W'(1703);
      4'd4:    base = CNT_W'(1607);
      4'd5:    base = CNT_W'(1517);
      4'd6:    base = CNT_W'(1432);
      4'd7:    base = CNT_W'(1351);
      4'd8:    base = CNT_W'(1276);
      4'd9:    base = CNT_W'(1204);
      4'd10:   base = CNT_W'(1136);
      4'd11:   base = CNT_W'(1073);
      4'd12:   base = CNT_W'(1012);
      default: base = '0;
    endcase
    return base >> oct;
  endfunction

  assign tick_rise_c = tick & ~tick_q;
  assign boundary_c  = tick_rise_c && (cnt_q == half_q - CNT_W'(1));
  assign eff_flag_c  = key_valid | pend_flag_q;
  assign eff_note_c  = key_valid ? note   : pend_note_q;
  assign eff_oct_c   = key_valid ? octave : pend_oct_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_q      <= 1'b0;
      cnt_q       <= '0;
      half_q      <= '0;
      audio_q     <= 1'b0;
      active_q    <= 1'b0;
      pend_note_q <= 4'd0;
      pend_oct_q  <= 2'd0;
      pend_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      audio_q     <= audio_d;
      active_q    <= (state_d == PLAY);
      pend_note_q <= pend_note_d;
      pend_oct_q  <= pend_oct_d;
      pend_flag_q <= pend_flag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    audio_d     = audio_q;
    pend_note_d = pend_note_q;
    pend_oct_d  = pend_oct_q;
    pend_flag_d = pend_flag_q;
    case (state_q)
      IDLE: begin
        audio_d = 1'b0;
        cnt_d   = '0;
        if (key_valid && playable(note)) begin
          half_d  = half_of(note, octave);
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (key_valid) begin
          pend_note_d = note;
          pend_oct_d  = octave;
          pend_flag_d = 1'b1;
        end
        if (boundary_c) begin
          cnt_d = '0;
          // A strobe in the boundary cycle wins over any stored change.
          if (eff_flag_c) begin
            pend_flag_d = 1'b0;
            if (playable(eff_note_c)) begin
              half_d  = half_of(eff_note_c, eff_oct_c);
              audio_d = ~audio_q;
            end else begin
              audio_d = 1'b0;
              state_d = IDLE;
            end
          end else begin
            audio_d = ~audio_q;
          end
        end else if (tick_rise_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign audio       = audio_q;
  assign note_active = active_q;

endmodule

// File: tb/tb_tone_gen.sv
// Directed self-checking bench for tone_gen: tone timing, deferred and
// colliding note changes, silencing and mid-tone reset.
module tb_tone_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       key_valid;
  logic [3:0] note;
  logic [1:0] octave;
  logic       audio;
  logic       note_active;

  int checks = 0;
  int errors = 0;

  tone_gen #(.CNT_W(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .key_valid   (key_valid),
    .note        (note),
    .octave      (octave),
    .audio       (audio),
    .note_active (note_active)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n tick rises, each tick high one cycle then low one cycle.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic strobe(input logic [3:0] n, input logic [1:0] o);
    key_valid = 1'b1;
    note      = n;
    octave    = o;
    step();
    key_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; key_valid = 1'b0; note = 4'd0; octave = 2'd0;
    #1;
    // Reset for 2 cycles while toggling tick.
    tick = 1'b1; step();
    tick = 1'b0; step();
    check("reset_audio", audio, 1'b0);
    check("reset_active", note_active, 1'b0);
    rst = 1'b0;
    do_ticks(5);
    check("idle_ticks_audio", audio, 1'b0);
    check("idle_ticks_active", note_active, 1'b0);

    // A, octave 3: half = 1136>>3 = 142.
    strobe(4'd10, 2'd3);
    check("start_active", note_active, 1'b1);
    check("start_audio", audio, 1'b0);
    do_ticks(141);
    check("basic_before_rise", audio, 1'b0);
    do_ticks(1);
    check("basic_first_rise", audio, 1'b1);

    // Deferred change to C oct 3 (238) strobed at cnt=50.
    do_ticks(50);
    strobe(4'd1, 2'd3);
    do_ticks(91);
    check("defer_old_half_holds", audio, 1'b1);
    do_ticks(1);
    check("defer_boundary_toggle", audio, 1'b0);
    do_ticks(237);
    check("defer_new_half_holds", audio, 1'b0);
    do_ticks(1);
    check("defer_new_half_toggle", audio, 1'b1);

    // Last wins: E then G (1276) strobed mid-half.
    do_ticks(10);
    strobe(4'd5, 2'd0);
    strobe(4'd8, 2'd0);
    do_ticks(227);
    check("lastwin_before_boundary", audio, 1'b1);
    do_ticks(1);
    check("lastwin_boundary", audio, 1'b0);
    do_ticks(1275);
    check("lastwin_g_holds", audio, 1'b0);
    do_ticks(1);
    check("lastwin_g_toggle", audio, 1'b1);

    // Strobe in the boundary cycle: B oct 2 -> 1012>>2 = 253.
    do_ticks(1275);
    tick = 1'b1; key_valid = 1'b1; note = 4'd12; octave = 2'd2;
    step();
    tick = 1'b0; key_valid = 1'b0;
    check("collide_toggle", audio, 1'b0);
    check("collide_active", note_active, 1'b1);
    step();
    do_ticks(252);
    check("collide_new_holds", audio, 1'b0);
    do_ticks(1);
    check("collide_new_toggle", audio, 1'b1);

    // Silence strobed mid-half.
    do_ticks(5);
    strobe(4'd0, 2'd0);
    do_ticks(247);
    check("silence_pre_audio", audio, 1'b1);
    check("silence_pre_active", note_active, 1'b1);
    tick = 1'b1; step();
    check("silence_audio", audio, 1'b0);
    check("silence_active", note_active, 1'b0);
    tick = 1'b0; step();

    // Silence code in IDLE is ignored.
    strobe(4'd14, 2'd1);
    check("idle_silence_active", note_active, 1'b0);
    do_ticks(3);
    check("idle_silence_audio", audio, 1'b0);

    // Reset while audio=1 with a pending change (E oct 3 = 189).
    strobe(4'd10, 2'd3);
    do_ticks(142);
    check("pre_reset_audio", audio, 1'b1);
    strobe(4'd5, 2'd3);
    do_ticks(3);
    rst = 1'b1; step();
    check("midreset_audio", audio, 1'b0);
    check("midreset_active", note_active, 1'b0);
    rst = 1'b0;
    strobe(4'd10, 2'd3);
    check("restart_active", note_active, 1'b1);
    do_ticks(141);
    check("restart_holds", audio, 1'b0);
    do_ticks(1);
    check("restart_rise", audio, 1'b1);
    do_ticks(141);
    check("no_stale_pending_holds", audio, 1'b1);
    do_ticks(1);
    check("no_stale_pending_fall", audio, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
